// File: rtl/quad_position_tracker_if.sv
// Encoder pins and paddle-position outputs of the quadrature tracker.
// slave = tracker side, master = encoder/consumer side.
interface quad_position_tracker_if #(
    parameter int POS_WIDTH = 6
);
    logic                 enc_a;
    logic                 enc_b;
    logic [POS_WIDTH-1:0] position;
    logic                 step_valid;
    logic                 step_dir;
    logic                 seq_error;

    modport slave (
        input  enc_a,
        input  enc_b,
        output position,
        output step_valid,
        output step_dir,
        output seq_error
    );

    modport master (
        output enc_a,
        output enc_b,
        input  position,
        input  step_valid,
        input  step_dir,
        input  seq_error
    );
endinterface

// File: rtl/quad_position_tracker.sv
// Quadrature encoder front end: sync, debounce, Gray decode, saturating position.
// Optional macro QDEC_X4_EN: every legal quarter step is a full position step.
module quad_position_tracker #(
    parameter int POS_WIDTH  = 6,
    parameter int POS_MAX    = 19,
    parameter int POS_INIT   = 10,
    parameter int TICK_DIV   = 1562,
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    quad_position_tracker_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_N  = SW'(STABLE_CNT);
    localparam logic [POS_WIDTH-1:0] PMAX  = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] PINIT = POS_WIDTH'(POS_INIT);

    logic [1:0]           sync_q1;
    logic [1:0]           sync_ab;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [1:0]           deb_ab;
    logic [1:0]           cand_ab;
    logic [SW-1:0]        stab_cnt;
    logic [SW-1:0]        stab_nxt;
    logic [1:0]           deb_prev;
    logic                 q_fwd;
    logic                 q_rev;
    logic                 q_err;
    logic                 step_up;
    logic                 step_dn;
    logic [POS_WIDTH-1:0] pos;
    logic                 valid_q;
    logic                 dir_q;
    logic                 err_q;

    // Two-flop synchroniser for the asynchronous encoder pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 2'b00;
            sync_ab <= 2'b00;
        end else begin
            sync_q1 <= {bus.enc_a, bus.enc_b};
            sync_ab <= sync_q1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running sample tick divider.
    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    // A new candidate restarts at 1; a repeated one counts on.
    always_comb begin
        stab_nxt = SW'(1);
        if (stab_cnt != '0 && cand_ab == sync_ab)
            stab_nxt = stab_cnt + 1'b1;
    end

    // Debounce: accept a level after STABLE_CNT consecutive ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_ab   <= 2'b00;
            cand_ab  <= 2'b00;
            stab_cnt <= '0;
        end else if (tick) begin
            if (sync_ab == deb_ab) begin
                stab_cnt <= '0;
            end else if (stab_nxt >= STABLE_N) begin
                deb_ab   <= sync_ab;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_nxt;
                cand_ab  <= sync_ab;
            end
        end
    end

    // Gray decode of the debounced level against its previous value.
    always_comb begin
        q_fwd = 1'b0;
        q_rev = 1'b0;
        q_err = 1'b0;
        if (deb_ab != deb_prev) begin
            if ((deb_ab ^ deb_prev) == 2'b11) begin
                q_err = 1'b1;
            end else begin
                case ({deb_prev, deb_ab})
                    4'b0001, 4'b0111,
                    4'b1110, 4'b1000: q_fwd = 1'b1;
                    default:          q_rev = 1'b1;
                endcase
            end
        end
    end

`ifdef QDEC_X4_EN
    // x4 mode: each legal quarter step is a full step.
    always_comb begin
        step_up = q_fwd;
        step_dn = q_rev;
    end
`else
    logic signed [2:0] acc;
    logic signed [2:0] acc_nxt;

    // Detent accumulator; a reversal only cancels progress.
    always_comb begin
        acc_nxt = acc;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (q_err) begin
            acc_nxt = '0;
        end else if (q_fwd) begin
            if (acc < 3'sd0) begin
                acc_nxt = '0;
            end else if (acc == 3'sd3) begin
                acc_nxt = '0;
                step_up = 1'b1;
            end else begin
                acc_nxt = acc + 3'sd1;
            end
        end else if (q_rev) begin
            if (acc > 3'sd0) begin
                acc_nxt = '0;
            end else if (acc == -3'sd3) begin
                acc_nxt = '0;
                step_dn = 1'b1;
            end else begin
                acc_nxt = acc - 3'sd1;
            end
        end
    end

    // Quarter-step accumulator register.
    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else       acc <= acc_nxt;
    end
`endif

    // Saturating position and its event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev <= 2'b00;
            pos      <= PINIT;
            valid_q  <= 1'b0;
            dir_q    <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            deb_prev <= deb_ab;
            valid_q  <= 1'b0;
            err_q    <= q_err;
            if (step_up && pos < PMAX) begin
                pos     <= pos + 1'b1;
                valid_q <= 1'b1;
                dir_q   <= 1'b1;
            end else if (step_dn && pos != '0) begin
                pos     <= pos - 1'b1;
                valid_q <= 1'b1;
                dir_q   <= 1'b0;
            end
        end
    end

    assign bus.position   = pos;
    assign bus.step_valid = valid_q;
    assign bus.step_dir   = dir_q;
    assign bus.seq_error  = err_q;
endmodule

// File: tb/tb_quad_position_tracker.sv
// Scoreboard bench for quad_position_tracker with a short tick divider.
// Stimulus queues expected pulses; a negedge monitor pops and compares.
module tb_quad_position_tracker;
    localparam int TD   = 4;
    localparam int HOLD = 6 * TD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] cur_ab = 2'b00;
    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_steps = 0;

    quad_position_tracker_if #(.POS_WIDTH(6)) bus ();

    quad_position_tracker #(
        .POS_WIDTH(6),
        .POS_MAX(19),
        .POS_INIT(10),
        .TICK_DIV(TD),
        .STABLE_CNT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] a;
        if (bus.step_valid || bus.seq_error) begin
            if (bus.step_valid) n_steps++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got err=%0b val=%0b pos=%0d, expected none",
                         bus.seq_error, bus.step_valid, bus.position);
            end else begin
                e = exp_q.pop_front();
                a = {bus.seq_error, bus.step_valid,
                     e[8] ? 1'b0 : bus.step_dir, bus.position};
                if (a !== e) begin
                    errors++;
                    $display("FAIL pulse: got %b, expected %b", a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive(input logic [1:0] v);
        @(posedge clk);
        bus.enc_a = v[1];
        bus.enc_b = v[0];
        cur_ab = v;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic qstep(input bit up, input bit ev, input int p);
        logic [1:0] n;
        n = up ? fwd(cur_ab) : rev(cur_ab);
        if (ev) exp_q.push_back({1'b0, 1'b1, up, 6'(p)});
        drive(n);
    endtask

    task automatic detent(input bit up, input bit ev, input int p);
        repeat (3) qstep(up, 1'b0, 0);
        qstep(up, ev, p);
    endtask

    task automatic do_reset();
        @(posedge clk);
        reset = 1'b1;
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        cur_ab = 2'b00;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_pos(input string name, input int p);
        @(negedge clk);
        chk(name, int'(bus.position), p);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_pos", int'(bus.position), 10);
        chk("rst_valid", int'(bus.step_valid), 0);
        chk("rst_dir", int'(bus.step_dir), 1);
        chk("rst_err", int'(bus.seq_error), 0);

`ifdef QDEC_X4_EN
        qstep(1'b1, 1'b1, 11);
        qstep(1'b1, 1'b1, 12);
        qstep(1'b0, 1'b1, 11);
        chk_pos("x4_pos", 11);
        chk("x4_dir", int'(bus.step_dir), 0);
`else
        repeat (3) qstep(1'b1, 1'b0, 0);
        chk_pos("fwd_partial", 10);
        qstep(1'b1, 1'b1, 11);
        chk_pos("fwd_detent", 11);
        chk("fwd_dir", int'(bus.step_dir), 1);

        do_reset();
        @(posedge clk);
        bus.enc_a = 1'b1;
        repeat (TD) @(posedge clk);
        bus.enc_a = 1'b0;
        repeat (HOLD) @(posedge clk);
        chk_pos("glitch_pos", 10);
        chk("glitch_deb", int'(dut.deb_ab), 0);

        do_reset();
        n_steps = 0;
        for (int i = 0; i < 12; i++)
            detent(1'b1, i < 9, (i < 9) ? 11 + i : 19);
        chk_pos("sat_pos", 19);
        chk("sat_pulses", n_steps, 9);
        detent(1'b0, 1'b1, 18);
        chk_pos("sat_back", 18);

        do_reset();
        exp_q.push_back({1'b1, 1'b0, 1'b0, 6'd10});
        drive(2'b11);
        chk_pos("illegal_pos", 10);
        chk("illegal_acc", int'(dut.acc), 0);
        detent(1'b1, 1'b1, 11);
        chk_pos("illegal_then_fwd", 11);

        do_reset();
        qstep(1'b1, 1'b0, 0);
        qstep(1'b1, 1'b0, 0);
        qstep(1'b0, 1'b0, 0);
        chk("rev_acc", int'(dut.acc), 0);
        detent(1'b0, 1'b1, 9);
        chk_pos("rev_pos", 9);
        chk("rev_dir", int'(bus.step_dir), 0);

        do_reset();
        repeat (3) qstep(1'b1, 1'b0, 0);
        do_reset();
        chk_pos("midrst_pos", 10);
        qstep(1'b1, 1'b0, 0);
        chk_pos("midrst_next", 10);
        chk("midrst_acc", int'(dut.acc), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
